// File: rtl/inst_fetch_if.sv
// ============================================================================
// inst_fetch_if : fetch-stage bus (imem request/response, decode control, ID regs)
// Revision 1.0
// ============================================================================
`default_nettype none

interface inst_fetch_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  modport master (
    output imem_en, imem_addr, id_valid, id_inst, id_pc, id_pc4,
    input  imem_rdata, id_stall, redirect_en, redirect_pc, flush, flush_pc
  );

  modport slave (
    input  imem_en, imem_addr, id_valid, id_inst, id_pc, id_pc4,
    output imem_rdata, id_stall, redirect_en, redirect_pc, flush, flush_pc
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch : PC, 1-cycle imem fetch, skid buffer and IF/ID register
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic   clk,
  input  wire logic   rst,
  inst_fetch_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;

  logic [31:0] addr_raw;
  logic [31:0] fetch_addr;
  logic        fetch_en;

  always_comb begin
    if (bus.flush)
      addr_raw = bus.flush_pc;
    else if (bus.redirect_en && !bus.id_stall)
      addr_raw = bus.redirect_pc;
    else
      addr_raw = pc_q;
    fetch_addr = {addr_raw[31:2], 2'b00};
  end

  assign fetch_en = ~rst & (bus.flush | ~bus.id_stall);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;

    if (fetch_en) begin
      pc_d          = fetch_addr + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_addr;
    end

    if (bus.flush) begin
      id_valid_d   = 1'b0;
      id_inst_d    = 32'h0;
      skid_valid_d = 1'b0;
    end else if (!bus.id_stall) begin
      // Skidded word is older than anything now arriving, so it goes first.
      if (skid_valid_q) begin
        id_valid_d   = 1'b1;
        id_inst_d    = skid_inst_q;
        id_pc_d      = skid_pc_q;
        id_pc4_d     = skid_pc_q + 32'd4;
        skid_valid_d = 1'b0;
      end else if (inflight_q) begin
        id_valid_d = 1'b1;
        id_inst_d  = bus.imem_rdata;
        id_pc_d    = inflight_pc_q;
        id_pc4_d   = inflight_pc_q + 32'd4;
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = 32'h0;
      end
    end else if (inflight_q && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = bus.imem_rdata;
      skid_pc_d    = inflight_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      skid_valid_q  <= 1'b0;
      skid_inst_q   <= 32'h0;
      skid_pc_q     <= 32'h0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= 32'h0;
      id_pc_q       <= 32'h0;
      id_pc4_q      <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_inst_q   <= skid_inst_d;
      skid_pc_q     <= skid_pc_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
    end
  end

  assign bus.imem_en   = fetch_en;
  assign bus.imem_addr = fetch_addr;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc4_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// tb_inst_fetch : directed self-checking bench for inst_fetch
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  localparam logic [31:0] C_KEY = 32'h5A5A_A5A5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  inst_fetch_if ifc ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  // Instruction memory: word content is a known function of its address.
  always @(posedge clk) begin
    if (ifc.imem_en) ifc.imem_rdata <= ifc.imem_addr ^ C_KEY;
    else             ifc.imem_rdata <= 32'hBAD0_BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'h0, ifc.id_valid}, {31'h0, v});
    if (v) begin
      chk({tag, ".inst"}, ifc.id_inst, pc ^ C_KEY);
      chk({tag, ".pc"},   ifc.id_pc,   pc);
      chk({tag, ".pc4"},  ifc.id_pc4,  pc + 32'd4);
    end else begin
      chk({tag, ".inst"}, ifc.id_inst, 32'h0);
    end
  endtask

  task automatic chk_f(input string tag, input logic en, input logic [31:0] addr);
    chk({tag, ".en"}, {31'h0, ifc.imem_en}, {31'h0, en});
    chk({tag, ".addr"}, ifc.imem_addr, addr);
  endtask

  initial begin
    rst             = 1'b1;
    ifc.id_stall    = 1'b0;
    ifc.redirect_en = 1'b0;
    ifc.redirect_pc = 32'h0;
    ifc.flush       = 1'b0;
    ifc.flush_pc    = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst.en", {31'h0, ifc.imem_en}, 32'h0);
    chk("rst.valid", {31'h0, ifc.id_valid}, 32'h0);
    chk("rst.inst", ifc.id_inst, 32'h0);
    chk("rst.pc", ifc.id_pc, 32'h0);
    chk("rst.pc4", ifc.id_pc4, 32'h0);

    // Straight-line fetch
    rst = 1'b0; #1;
    chk_f("c0", 1'b1, 32'h00);
    tick(); chk_f("c1", 1'b1, 32'h04); chk_id("c1", 1'b0, 32'h0);
    tick(); chk_f("c2", 1'b1, 32'h08); chk_id("c2", 1'b1, 32'h00);
    tick(); chk_f("c3", 1'b1, 32'h0C); chk_id("c3", 1'b1, 32'h04);
    tick(); chk_f("c4", 1'b1, 32'h10); chk_id("c4", 1'b1, 32'h08);
    tick(); chk_id("c5", 1'b1, 32'h0C);

    // Stall 3 cycles with 0x10 in flight
    ifc.id_stall = 1'b1; #1;
    chk_f("stall0", 1'b0, 32'h14);
    tick(); chk_f("stall1", 1'b0, 32'h14); chk_id("stall1", 1'b1, 32'h0C);
    tick(); chk_f("stall2", 1'b0, 32'h14); chk_id("stall2", 1'b1, 32'h0C);
    tick(); ifc.id_stall = 1'b0; #1;
    chk_id("release", 1'b1, 32'h0C); chk_f("release", 1'b1, 32'h14);
    tick(); chk_id("c9", 1'b1, 32'h10); chk_f("c9", 1'b1, 32'h18);
    tick(); chk_id("c10", 1'b1, 32'h14); chk_f("c10", 1'b1, 32'h1C);
    tick(); chk_id("c11", 1'b1, 32'h18);
    tick(); chk_id("c12", 1'b1, 32'h1C);

    // Redirect with delay slot
    tick(); chk_id("beq", 1'b1, 32'h20);
    ifc.redirect_en = 1'b1; ifc.redirect_pc = 32'h100; #1;
    chk_f("redir", 1'b1, 32'h100);
    tick(); ifc.redirect_en = 1'b0; #1;
    chk_id("dslot", 1'b1, 32'h24); chk_f("dslot", 1'b1, 32'h104);
    tick(); chk_id("tgt0", 1'b1, 32'h100); chk_f("tgt0", 1'b1, 32'h108);
    tick(); chk_id("tgt1", 1'b1, 32'h104);

    // Redirect while stalled is ignored
    ifc.id_stall = 1'b1; ifc.redirect_en = 1'b1; ifc.redirect_pc = 32'h200; #1;
    chk_f("stredir", 1'b0, 32'h10C);
    tick(); ifc.redirect_en = 1'b0; #1;
    chk_id("stredir", 1'b1, 32'h104); chk_f("stredir2", 1'b0, 32'h10C);

    // Flush while stalled with skid full
    ifc.flush = 1'b1; ifc.flush_pc = 32'h180; #1;
    chk_f("flush", 1'b1, 32'h180);
    tick(); ifc.flush = 1'b0; ifc.id_stall = 1'b0; #1;
    chk_id("flush1", 1'b0, 32'h0); chk_f("flush1", 1'b1, 32'h184);
    tick(); chk_id("flush2", 1'b1, 32'h180);
    tick(); chk_id("flush3", 1'b1, 32'h184);

    // Reset while skid is valid
    ifc.id_stall = 1'b1;
    tick(); rst = 1'b1; #1;
    chk("rststall.en", {31'h0, ifc.imem_en}, 32'h0);
    tick();
    chk("rststall.valid", {31'h0, ifc.id_valid}, 32'h0);
    chk("rststall.inst", ifc.id_inst, 32'h0);
    chk("rststall.pc", ifc.id_pc, 32'h0);
    chk("rststall.pc4", ifc.id_pc4, 32'h0);
    rst = 1'b0; ifc.id_stall = 1'b0; #1;
    chk_f("rr0", 1'b1, 32'h0);
    tick(); chk_id("rr1", 1'b0, 32'h0);
    tick(); chk_id("rr2", 1'b1, 32'h0);
    tick(); chk_id("rr3", 1'b1, 32'h4);

    // Flush beats redirect; flush_pc low bits masked
    ifc.flush = 1'b1; ifc.flush_pc = 32'h303;
    ifc.redirect_en = 1'b1; ifc.redirect_pc = 32'h400; #1;
    chk_f("flredir", 1'b1, 32'h300);
    tick(); ifc.flush = 1'b0; ifc.redirect_en = 1'b0; #1;
    chk_id("flredir1", 1'b0, 32'h0); chk_f("flredir1", 1'b1, 32'h304);
    tick(); chk_id("flredir2", 1'b1, 32'h300);

    // Redirect to top of address space, PC wraps
    ifc.redirect_en = 1'b1; ifc.redirect_pc = 32'hFFFF_FFFE; #1;
    chk_f("wrap0", 1'b1, 32'hFFFF_FFFC);
    tick(); ifc.redirect_en = 1'b0; #1;
    chk_id("wrap1", 1'b1, 32'h304); chk_f("wrap1", 1'b1, 32'h0);
    tick(); chk_id("wrap2", 1'b1, 32'hFFFF_FFFC); chk_f("wrap2", 1'b1, 32'h4);
    tick(); chk_id("wrap3", 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
